// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Halts the core, walks the register file through one read port
//               and streams (address, value) beats over valid/ready.
//               Optional macro REGFILE_DUMP_X0_EN includes x0 in the walk.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int REG_COUNT    = 32,
    parameter int HALT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_halt_req,
    input  logic        i_halt_ack,
    output logic [4:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic [4:0]  o_dout_addr,
    output logic [31:0] o_dout_data,
    output logic        o_dout_last,
    output logic        o_done,
    output logic        o_err
);

    localparam int         c_TW         = $clog2(HALT_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(HALT_TIMEOUT - 1);
    localparam logic [4:0] c_LAST       = 5'(REG_COUNT - 1);
`ifdef REGFILE_DUMP_X0_EN
    localparam logic [4:0] c_FIRST      = 5'd0;
`else
    localparam logic [4:0] c_FIRST      = 5'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HALT   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [c_TW-1:0]   r_timer,  w_timer_nxt;
    logic [4:0]        r_rd_addr, w_rd_addr_nxt;
    logic              r_dout_valid, w_valid_nxt;
    logic              r_dout_last,  w_last_nxt;
    logic [4:0]        r_dout_addr,  w_daddr_nxt;
    logic [31:0]       r_dout_data,  w_ddata_nxt;
    logic              r_halt_req,   w_halt_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_err,        w_err_nxt;
    logic [31:0]       w_load_data;

`ifdef REGFILE_DUMP_X0_EN
    // x0 is architecturally zero regardless of what the read port returns
    assign w_load_data = (r_rd_addr == 5'd0) ? 32'd0 : i_rd_data;
`else
    assign w_load_data = i_rd_data;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_rd_addr_nxt = r_rd_addr;
        w_valid_nxt   = r_dout_valid;
        w_last_nxt    = r_dout_last;
        w_daddr_nxt   = r_dout_addr;
        w_ddata_nxt   = r_dout_data;
        w_halt_nxt    = r_halt_req;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_HALT;
                    w_halt_nxt  = 1'b1;
                    w_timer_nxt = '0;
                end
            end
            S_HALT: begin
                if (i_halt_ack) begin
                    w_state_nxt   = S_STREAM;
                    w_rd_addr_nxt = c_FIRST;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_halt_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_STREAM, S_DRAIN: begin
                // Losing the halt wins over any beat handshake this cycle
                if (!i_halt_ack) begin
                    w_state_nxt   = S_IDLE;
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = 1'b0;
                    w_halt_nxt    = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_rd_addr_nxt = 5'd0;
                end else if (r_state == S_STREAM) begin
                    if (!r_dout_valid || i_dout_ready) begin
                        w_ddata_nxt = w_load_data;
                        w_daddr_nxt = r_rd_addr;
                        w_valid_nxt = 1'b1;
                        if (r_rd_addr == c_LAST) begin
                            w_last_nxt  = 1'b1;
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_rd_addr_nxt = r_rd_addr + 5'd1;
                        end
                    end
                end else if (r_dout_valid && i_dout_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = 1'b0;
                    w_halt_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_rd_addr_nxt = 5'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_rd_addr    <= 5'd0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dout_addr  <= 5'd0;
            r_dout_data  <= 32'd0;
            r_halt_req   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_dout_valid <= w_valid_nxt;
            r_dout_last  <= w_last_nxt;
            r_dout_addr  <= w_daddr_nxt;
            r_dout_data  <= w_ddata_nxt;
            r_halt_req   <= w_halt_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_halt_req   = r_halt_req;
    assign o_rd_addr    = r_rd_addr;
    assign o_dout_valid = r_dout_valid;
    assign o_dout_addr  = r_dout_addr;
    assign o_dout_data  = r_dout_data;
    assign o_dout_last  = r_dout_last;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
`default_nettype wire
